// File: rtl/img_proc_ctrl_if.sv
// img_proc_ctrl_if: configuration/status register bus for img_proc_ctrl.
// master drives write strobe, address and write data; slave returns read data.
interface img_proc_ctrl_if;
   logic        cfg_we;
   logic [1:0]  cfg_addr;
   logic [7:0]  cfg_wdata;
   logic [15:0] cfg_rdata;

   modport master (
      output cfg_we,
      output cfg_addr,
      output cfg_wdata,
      input  cfg_rdata
   );

   modport slave (
      input  cfg_we,
      input  cfg_addr,
      input  cfg_wdata,
      output cfg_rdata
   );
endinterface

// File: rtl/img_proc_ctrl.sv
// img_proc_ctrl: frame/line tracking, 3x3 window qualification and mode control
// for the image_proc datapath. Optional statistics counters (frame count at
// addr 2, saturating error-event count at addr 3) are built when the macro
// IMG_PROC_CTRL_STATS_EN is defined; otherwise those addresses read zero.
module img_proc_ctrl #(
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              iFVAL,
   input  logic              iDVAL,
   img_proc_ctrl_if.slave    cfg,
   output logic [9:0]        oX,
   output logic [9:0]        oY,
   output logic              oWIN_VALID,
   output logic [1:0]        oMODE,
   output logic [2:0]        oMAG_SHIFT,
   output logic              oFRAME_DONE,
   output logic              oLINE_ERR
);

   localparam int unsigned CW = 10;
   localparam logic [CW-1:0] X_END = CW'(IMG_W);
   localparam logic [CW-1:0] Y_END = CW'(IMG_H);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARMED = 3'd1,
      LINE  = 3'd2,
      BLANK = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t          state;
   logic [CW-1:0]   x;
   logic [CW-1:0]   y;
   logic [7:0]      shadow;
   logic            err_evt;
   logic            err_clr;
   logic            pix_live;
   logic [15:0]     stat_frames;
   logic [15:0]     stat_errs;

   // Error events: bad line length, overlong line, frame cut mid-line, too many lines.
   always_comb begin
      err_evt = 1'b0;
      case (state)
         LINE: begin
            if (!iFVAL)     err_evt = (x != X_END);
            else if (iDVAL) err_evt = (x == X_END);
            else            err_evt = (x != X_END);
         end
         BLANK:   err_evt = iFVAL & iDVAL & (y >= Y_END);
         default: err_evt = 1'b0;
      endcase
   end

   assign err_clr  = cfg.cfg_we & (cfg.cfg_addr == 2'd1) & cfg.cfg_wdata[0];
   assign pix_live = iFVAL & iDVAL &
                     ((state == ARMED) | (state == LINE) | (state == BLANK));

   // Pixel position of the current iDVAL cycle and window qualification.
   assign oX         = x;
   assign oY         = y;
   assign oWIN_VALID = pix_live & (x >= CW'(2)) & (y >= CW'(2)) & (x < X_END);

   // Frame FSM, counters, shadow/active config and sticky error flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         x           <= '0;
         y           <= '0;
         shadow      <= 8'h00;
         oMODE       <= 2'd0;
         oMAG_SHIFT  <= 3'd4;
         oFRAME_DONE <= 1'b0;
         oLINE_ERR   <= 1'b0;
      end else begin
         oFRAME_DONE <= 1'b0;
         if (cfg.cfg_we && (cfg.cfg_addr == 2'd0)) shadow <= cfg.cfg_wdata;
         // A new error outranks a coincident clear so no event is lost.
         if (err_evt)      oLINE_ERR <= 1'b1;
         else if (err_clr) oLINE_ERR <= 1'b0;

         case (state)
            IDLE: begin
               x <= '0;
               y <= '0;
               if (shadow[0]) state <= ARMED;
            end
            ARMED: begin
               if (!shadow[0]) begin
                  state <= IDLE;
               end else if (iFVAL && iDVAL) begin
                  // Frame start: first pixel is x=0; latch config from the pre-write shadow.
                  state      <= LINE;
                  oMODE      <= shadow[2:1];
                  oMAG_SHIFT <= shadow[5:3];
                  x          <= CW'(1);
               end
            end
            LINE: begin
               if (!iFVAL) begin
                  state       <= DONE;
                  oFRAME_DONE <= 1'b1;
                  x           <= '0;
                  y           <= '0;
               end else if (iDVAL) begin
                  if (x != X_END) x <= x + CW'(1);
               end else begin
                  state <= BLANK;
                  x     <= '0;
                  if (y != Y_END) y <= y + CW'(1);
               end
            end
            BLANK: begin
               if (!iFVAL) begin
                  state       <= DONE;
                  oFRAME_DONE <= 1'b1;
                  x           <= '0;
                  y           <= '0;
               end else if (iDVAL) begin
                  state <= LINE;
                  x     <= CW'(1);
               end
            end
            DONE: begin
               x     <= '0;
               y     <= '0;
               state <= shadow[0] ? ARMED : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef IMG_PROC_CTRL_STATS_EN
   logic [15:0] frame_cnt;
   logic [15:0] err_cnt;

   // Wrapping frame counter and saturating error-event counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_cnt <= 16'h0000;
         err_cnt   <= 16'h0000;
      end else begin
         if (state == DONE) frame_cnt <= frame_cnt + 16'd1;
         if (err_evt && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
      end
   end

   assign stat_frames = frame_cnt;
   assign stat_errs   = err_cnt;
`else
   assign stat_frames = 16'h0000;
   assign stat_errs   = 16'h0000;
`endif

   // Register read mux.
   always_comb begin
      cfg.cfg_rdata = 16'h0000;
      case (cfg.cfg_addr)
         2'd0:    cfg.cfg_rdata = {8'h00, shadow};
         2'd1:    cfg.cfg_rdata = {3'(state), oLINE_ERR, y, 2'b00};
         2'd2:    cfg.cfg_rdata = stat_frames;
         default: cfg.cfg_rdata = stat_errs;
      endcase
   end

endmodule

// File: tb/tb_img_proc_ctrl.sv
// tb_img_proc_ctrl: directed test of img_proc_ctrl with hand-computed expectations.
module tb_img_proc_ctrl;

`ifdef IMG_PROC_CTRL_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       fval;
   logic       dval;
   logic [9:0] ox;
   logic [9:0] oy;
   logic       win;
   logic [1:0] mode;
   logic [2:0] shift;
   logic       fdone;
   logic       lerr;

   int n_chk  = 0;
   int n_err  = 0;
   int n_done = 0;

   img_proc_ctrl_if cfg_bus ();

   img_proc_ctrl #(.IMG_W(640), .IMG_H(480)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .iFVAL       (fval),
      .iDVAL       (dval),
      .cfg         (cfg_bus),
      .oX          (ox),
      .oY          (oy),
      .oWIN_VALID  (win),
      .oMODE       (mode),
      .oMAG_SHIFT  (shift),
      .oFRAME_DONE (fdone),
      .oLINE_ERR   (lerr)
   );

   always #5 clk = ~clk;

   // Count frame-done pulses away from the active edge.
   always @(negedge clk) if (fdone) n_done++;

   initial begin
      #3ms;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
      cfg_bus.cfg_we    = 1'b1;
      cfg_bus.cfg_addr  = a;
      cfg_bus.cfg_wdata = d;
      step();
      cfg_bus.cfg_we    = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] a, input logic [15:0] exp);
      cfg_bus.cfg_addr = a;
      #1;
      check_eq(tag, 32'(cfg_bus.cfg_rdata), 32'(exp));
   endtask

   task automatic run_line(input int len, input int line_no, input bit chk_px);
      for (int i = 0; i < len; i++) begin
         fval = 1'b1;
         dval = 1'b1;
         #1;
         if (chk_px) begin
            check_eq("px_x", 32'(ox), (i < 640) ? i : 640);
            check_eq("px_y", 32'(oy), line_no);
            check_eq("win", 32'(win), 32'((i >= 2) && (line_no >= 2) && (i < 640)));
         end
         step();
      end
      dval = 1'b0;
   endtask

   task automatic blank(input int n);
      dval = 1'b0;
      repeat (n) step();
   endtask

   task automatic end_frame();
      fval = 1'b0;
      dval = 1'b0;
      step();
      check_eq("fdone_hi", 32'(fdone), 1);
      step();
      check_eq("fdone_lo", 32'(fdone), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      fval = 1'b0;
      dval = 1'b0;
      cfg_bus.cfg_we = 1'b0;
      cfg_bus.cfg_addr = 2'd0;
      cfg_bus.cfg_wdata = 8'h00;
      repeat (3) step();

      // Reset state
      check_eq("rst_mode", 32'(mode), 0);
      check_eq("rst_shift", 32'(shift), 4);
      check_eq("rst_fdone", 32'(fdone), 0);
      check_eq("rst_lerr", 32'(lerr), 0);
      check_eq("rst_x", 32'(ox), 0);
      check_eq("rst_y", 32'(oy), 0);
      rd_chk("rst_a0", 2'd0, 16'h0000);
      rd_chk("rst_a1", 2'd1, 16'h0000);
      rd_chk("rst_a2", 2'd2, 16'h0000);
      rd_chk("rst_a3", 2'd3, 16'h0000);
      rst_n = 1'b1;

      // Pixels in IDLE are ignored
      fval = 1'b1;
      dval = 1'b1;
      step();
      step();
      check_eq("idle_x", 32'(ox), 0);
      check_eq("idle_win", 32'(win), 0);
      rd_chk("idle_a1", 2'd1, 16'h0000);
      fval = 1'b0;
      dval = 1'b0;

      // Enable, mode 1, shift 4
      cfg_write(2'd0, 8'h23);
      step();
      rd_chk("armed_a1", 2'd1, 16'h2000);
      rd_chk("shadow_a0", 2'd0, 16'h0023);

      // Frame 1: 6 lines x 640, 20-cycle blanking
      fval = 1'b1;
      step();
      step();
      check_eq("pre_mode", 32'(mode), 0);
      for (int l = 0; l < 6; l++) begin
         run_line(640, l, 1'b1);
         dval = 1'b0;
         step();
         if (l == 0) begin
            rd_chk("blank_a1", 2'd1, 16'h6004);
            check_eq("f1_mode", 32'(mode), 1);
            check_eq("f1_shift", 32'(shift), 4);
         end
         blank((l == 5) ? 2 : 19);
      end
      end_frame();
      check_eq("f1_ndone", n_done, 1);
      check_eq("f1_lerr", 32'(lerr), 0);
      rd_chk("f1_a1", 2'd1, 16'h2000);

      // Frame 2: short line sets sticky error; mid-frame mode write
      fval = 1'b1;
      step();
      run_line(640, 0, 1'b0);
      dval = 1'b0;
      step();
      check_eq("f2_ok_lerr", 32'(lerr), 0);
      blank(3);
      run_line(639, 1, 1'b0);
      #1;
      check_eq("f2_pre_lerr", 32'(lerr), 0);
      step();
      check_eq("f2_lerr", 32'(lerr), 1);
      rd_chk("f2_a1", 2'd1, 16'h7008);
      cfg_write(2'd0, 8'h27);
      check_eq("f2_mode_hold", 32'(mode), 1);
      blank(2);
      run_line(640, 2, 1'b0);
      check_eq("f2_mode_hold2", 32'(mode), 1);
      dval = 1'b0;
      step();
      blank(2);
      end_frame();
      check_eq("f2_sticky", 32'(lerr), 1);
      cfg_write(2'd1, 8'h01);
      check_eq("f2_clr", 32'(lerr), 0);

      // Frame 3: cfg write coincident with frame-start load, then reset mid-line
      fval = 1'b1;
      step();
      check_eq("f3_pre_mode", 32'(mode), 1);
      dval = 1'b1;
      cfg_bus.cfg_we = 1'b1;
      cfg_bus.cfg_addr = 2'd0;
      cfg_bus.cfg_wdata = 8'h33;
      #1;
      check_eq("f3_x0", 32'(ox), 0);
      step();
      cfg_bus.cfg_we = 1'b0;
      check_eq("f3_mode", 32'(mode), 3);
      check_eq("f3_shift", 32'(shift), 4);
      rd_chk("f3_a0", 2'd0, 16'h0033);
      run_line(639, 0, 1'b0);
      blank(2);
      run_line(640, 1, 1'b0);
      blank(2);
      run_line(640, 2, 1'b0);
      blank(2);
      run_line(300, 3, 1'b1);
      dval = 1'b1;
      #1;
      check_eq("f3_x300", 32'(ox), 300);
      check_eq("f3_y3", 32'(oy), 3);
      rst_n = 1'b0;
      step();
      check_eq("mrst_x", 32'(ox), 0);
      check_eq("mrst_y", 32'(oy), 0);
      check_eq("mrst_shift", 32'(shift), 4);
      check_eq("mrst_mode", 32'(mode), 0);
      rd_chk("mrst_a1", 2'd1, 16'h0000);
      rd_chk("mrst_a0", 2'd0, 16'h0000);
      rst_n = 1'b1;
      dval = 1'b0;
      fval = 1'b0;
      step();

      // Three frames for statistics: clean, overlong (2 events), short (1 event)
      cfg_write(2'd0, 8'h23);
      step();
      fval = 1'b1;
      step();
      run_line(640, 0, 1'b0);
      dval = 1'b0;
      step();
      blank(1);
      end_frame();

      fval = 1'b1;
      step();
      run_line(642, 0, 1'b1);
      dval = 1'b0;
      step();
      check_eq("long_lerr", 32'(lerr), 1);
      blank(1);
      end_frame();
      cfg_write(2'd1, 8'h01);
      check_eq("long_clr", 32'(lerr), 0);

      fval = 1'b1;
      step();
      run_line(639, 0, 1'b0);
      dval = 1'b0;
      step();
      check_eq("short_lerr", 32'(lerr), 1);
      blank(1);
      end_frame();

      rd_chk("stat_frames", 2'd2, STATS ? 16'd3 : 16'd0);
      rd_chk("stat_errs", 2'd3, STATS ? 16'd3 : 16'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/img_proc_ctrl.md
IMG_PROC_CTRL -- requirements
Module: img_proc_ctrl

Interface
REQ-001 Parameter: IMG_W, 640, active pixels per line.
REQ-002 Parameter: IMG_H, 480, active lines per frame.
REQ-003 Port: clk  in  1  clock; all logic on rising edge.
REQ-004 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-005 Port: iFVAL  in  1  frame valid from capture path.
REQ-006 Port: iDVAL  in  1  pixel valid; same cadence fed to image_proc.
REQ-007 Port: cfg_we  in  1  config write strobe.
REQ-008 Port: cfg_addr  in  2  config/status register address.
REQ-009 Port: cfg_wdata  in  8  config write data.
REQ-010 Port: cfg_rdata  out  16  read data for cfg_addr, combinational.
REQ-011 Port: oX  out  10  column of the current pixel.
REQ-012 Port: oY  out  10  row of the current pixel.
REQ-013 Port: oWIN_VALID  out  1  3x3 window fully inside the image for the current pixel.
REQ-014 Port: oMODE  out  2  active mode: 0 passthrough, 1 Sobel-X, 2 Sobel-Y, 3 magnitude.
REQ-015 Port: oMAG_SHIFT  out  3  active magnitude right-shift.
REQ-016 Port: oFRAME_DONE  out  1  one-cycle end-of-frame pulse.
REQ-017 Port: oLINE_ERR  out  1  sticky line-length/framing error flag.

Function
REQ-018 States SHALL be IDLE, ARMED, LINE, BLANK, DONE.
REQ-019 IDLE->ARMED when the shadow enable bit is 1; ARMED->IDLE when the shadow enable bit is 0.
REQ-020 ARMED->LINE on the first iDVAL=1 with iFVAL=1; shadow config copies to active regs (oMODE, oMAG_SHIFT) on that same edge.
REQ-021 LINE: each iDVAL=1 cycle increments x; LINE->BLANK on iDVAL=0; x clears to 0 and y increments on that edge.
REQ-022 BLANK->LINE on iDVAL=1 with iFVAL=1; blanking length unbounded, including zero cycles.
REQ-023 iFVAL falling in LINE or BLANK SHALL cause ->DONE; oFRAME_DONE=1 for exactly the DONE cycle; then ->ARMED if enabled, else IDLE; x and y clear.
REQ-024 oX/oY SHALL be combinational from counters, describing the pixel on iDVAL in the same cycle; oWIN_VALID = iDVAL & x>=2 & y>=2 & x<IMG_W.
REQ-025 Line ending with x!=IMG_W, iDVAL=1 while x==IMG_W (extra pixels: x saturates, oWIN_VALID=0), iFVAL falling mid-line, or y reaching IMG_H: set oLINE_ERR.
REQ-026 oLINE_ERR SHALL clear only on reset or on a write to addr 1 with bit0=1.
REQ-027 Addr 0 write: bit0 enable, bits2:1 mode, bits5:3 mag shift into shadow; read returns {8'h0, shadow}.
REQ-028 Addr 1 read: {state[2:0], oLINE_ERR, y[9:0], 2'b0}.
REQ-029 A cfg write coincident with the frame-start load SHALL NOT affect the current frame; the pre-write shadow value loads.
REQ-030 Clearing enable mid-frame SHALL let the current frame complete; next state after DONE is IDLE.
REQ-031 iDVAL in IDLE or DONE SHALL be ignored (no count, oWIN_VALID=0).

Reset
REQ-032 On rst_n=0 at a clock edge: state IDLE, x=y=0, shadow=8'h00, oMODE=0, oMAG_SHIFT=4, oFRAME_DONE=0, oLINE_ERR=0, stats counters 0.
REQ-033 Reset mid-frame SHALL abort immediately; the next frame is counted from its first iDVAL after re-arm.

Configuration
REQ-034 With IMG_PROC_CTRL_STATS_EN defined: 16-bit wrapping frame counter (increments in DONE) readable at addr 2; 16-bit saturating error-event counter at addr 3.
REQ-035 Without IMG_PROC_CTRL_STATS_EN: no counters; reads of addr 2 and 3 return 16'h0000.

Verification
REQ-036 Write addr0=8'h23 (en, mode 1, shift 4); 6 lines x 640 px, 20-cycle blanking -> oMODE=1, oMAG_SHIFT=4, oLINE_ERR=0, one oFRAME_DONE pulse.
REQ-037 Same frame -> oWIN_VALID=0 for all px of y=0,1 and x=0,1; =1 at (x=2,y=2) and (x=639,y=5).
REQ-038 Line of 639 px -> oLINE_ERR=1 after iDVAL falls; write addr1=1 -> 0.
REQ-039 Write mode 3 mid-frame -> oMODE stays 1 until next frame's first pixel, then 3.
REQ-040 rst_n=0 at x=300,y=3 -> next cycle state IDLE, oX=oY=0, oMAG_SHIFT=4.
REQ-041 STATS build: 3 frames -> addr2 reads 3; non-STATS build -> addr2 reads 0.
